// File: rtl/vga_frame_monitor.sv
// Receiver-side checker for a TinyVGA-style 8-bit bus: verifies sync timing and
// blanking, and produces a rotate-xor signature of every good frame's active pixels.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        clear,
  output logic        locked,
  output logic        frame_valid,
  output logic [15:0] frame_count,
  output logic [15:0] frame_crc,
  output logic        err_h,
  output logic        err_v,
  output logic        err_blank
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] X_LO      = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] X_HI      = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] Y_LO      = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] Y_HI      = 11'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [11:0] x_inc_sat(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] y_inc_sat(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [5:0] p);
    return {c[14:0], c[15]} ^ {10'b0, p};
  endfunction

  logic        hs_p0, vs_p0, hs_p1, vs_p1;
  logic [5:0]  pix_p0, pix_p1;
  logic [11:0] x;
  logic [10:0] y;
  logic [15:0] crc;
  logic        frm_err;
  state_t      state;

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic h_bad, v_bad, in_win, blank_bad, checking;

  // Stage p0: register the pins, normalise sync polarity, regroup RGB as {R1,R0,G1,G0,B1,B0}
  // Stage p1: previous sample for edge detection; pixel delayed to line up with x/y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      pix_p0 <= 6'd0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      pix_p1 <= 6'd0;
    end else begin
      hs_p0  <= vga_in[0] ^ SYNC_NEG;
      vs_p0  <= vga_in[4] ^ SYNC_NEG;
      pix_p0 <= {vga_in[7], vga_in[3], vga_in[6], vga_in[2], vga_in[5], vga_in[1]};
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      pix_p1 <= pix_p0;
    end
  end

  assign hs_rise = hs_p0 & ~hs_p1;
  assign hs_fall = ~hs_p0 & hs_p1;
  assign vs_rise = vs_p0 & ~vs_p1;
  assign vs_fall = ~vs_p0 & vs_p1;

  // Counters hold the pre-edge value on an edge cycle, so count+1 is the measured length.
  assign h_bad = (hs_rise && ((x + 12'd1) != H_TOTAL_C)) ||
                 (hs_fall && ((x + 12'd1) != H_SYNC_C));
  assign v_bad = (vs_rise && ((y + 11'd1) != V_TOTAL_C)) ||
                 (vs_fall && ((y + 11'd1) != V_SYNC_C));

  assign in_win    = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign blank_bad = !in_win && (pix_p1 != 6'd0);
  assign checking  = (state != ST_SEARCH);

  // Stage p2: position counters and running signature
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= 12'd0;
      y   <= 11'd0;
      crc <= 16'd0;
    end else begin
      x <= hs_rise ? 12'd0 : x_inc_sat(x);
      if (vs_rise) begin
        y <= 11'd0;
      end else if (hs_rise) begin
        y <= y_inc_sat(y);
      end
      if (vs_rise) begin
        crc <= 16'd0;
      end else if (in_win) begin
        crc <= crc_step(crc, pix_p1);
      end
    end
  end

  // Lock FSM, sticky flags and frame publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      locked      <= 1'b0;
      frm_err     <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= 16'd0;
      frame_crc   <= 16'd0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      err_blank   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      if (checking) begin
        if (h_bad)     err_h     <= 1'b1;
        if (v_bad)     err_v     <= 1'b1;
        if (blank_bad) err_blank <= 1'b1;
      end

      case (state)
        ST_SEARCH: begin
          frm_err <= 1'b0;
          if (vs_rise) begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (vs_rise) begin
            frm_err <= 1'b0;
            if (!(frm_err || h_bad || v_bad)) begin
              state       <= ST_LOCKED;
              locked      <= 1'b1;
              frame_valid <= 1'b1;
              frame_crc   <= crc;
              frame_count <= frame_count + 16'd1;
            end
          end else if (h_bad || v_bad) begin
            frm_err <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (h_bad || v_bad) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end else if (vs_rise) begin
            frame_valid <= 1'b1;
            frame_crc   <= crc;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase

      // Clear overrides both flag setting and the count bump; frame_crc still updates.
      if (clear) begin
        err_h       <= 1'b0;
        err_v       <= 1'b0;
        err_blank   <= 1'b0;
        frame_count <= 16'd0;
      end
    end
  end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receiver-side counterpart to the screensaver's TinyVGA PMOD output.
- Consumes the 8-bit uo_out-style bus (R1 G1 B1 VS R0 G0 B0 HS) in the pixel-clock domain.
- Checks hsync/vsync timing against 640x480@60 parameters, checks that RGB is zero during blanking, and produces a per-frame pixel signature.
- Used as an on-chip or FPGA-side self-check, and as a synthesizable checker instantiated beside the top in system benches.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front-porch pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, back-porch pixels
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, front-porch lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, back-porch lines
- SYNC_NEG, 1, 1 = sync pulses are active-low

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vga_in  in  8  {R1,G1,B1,VS,R0,G0,B0,HS}, bit7..bit0
- clear  in  1  synchronous; clears sticky error flags and frame_count
- locked  out  1  timing has matched for at least one complete frame
- frame_valid  out  1  one-cycle pulse when frame_crc/frame_count update
- frame_count  out  16  completed good frames, wraps 0xFFFF->0
- frame_crc  out  16  signature of the last completed frame
- err_h  out  1  sticky: hsync period or width mismatch
- err_v  out  1  sticky: vsync period (lines) or width mismatch
- err_blank  out  1  sticky: nonzero RGB outside the active window

Behaviour:
- Reset: all outputs 0, FSM in SEARCH, all counters 0.
- Input stage: vga_in is registered once. Sync polarity is normalised: hs = HS ^ SYNC_NEG, vs = VS ^ SYNC_NEG. Edge detection runs on the registered value. Pin-to-edge latency is 2 cycles.
- Horizontal counter:
  - x (12 bit) resets to 0 on the cycle the hs rising edge is detected, otherwise increments; saturates at 4095.
  - On each hs rising edge, the previous x+1 must equal H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800); otherwise set err_h.
  - On the hs falling edge, x+1 must equal H_SYNC; otherwise set err_h.
- Vertical counter:
  - y (11 bit) increments on each hs rising edge; saturates at 2047.
  - A vs rising edge resets y to 0. This takes priority when it coincides with an hs edge.
  - On a vs rising edge, the line count since the previous vs rise must equal V_TOTAL (525); otherwise set err_v.
  - The vs pulse must span exactly V_SYNC hs rises; otherwise set err_v.
- Active window: x in [H_SYNC+H_BACK, +H_ACTIVE) = [144,784) and y in [V_SYNC+V_BACK, +V_ACTIVE) = [35,515).
  - Pixel pix = {R1,R0,G1,G0,B1,B0}.
  - Outside the window, pix != 0 sets err_blank. This check applies in MEASURE and LOCKED only.
- Signature:
  - At each active pixel: crc <= {crc[14:0],crc[15]} ^ {10'b0,pix}.
  - crc resets to 0 at each vs rising edge, after being latched.
- FSM:
  - SEARCH: wait for the first vs rise, then go to MEASURE. No error flags are set in SEARCH.
  - MEASURE: at the next vs rise, if no h/v error occurred during the frame, go to LOCKED with locked=1. Otherwise stay in MEASURE, restart the measurement, and raise the sticky flags.
  - LOCKED: on any h or v mismatch, go to SEARCH and set locked=0 the next cycle. A blank error sets err_blank but keeps lock.
- Frame completion (LOCKED, vs rise): on the next cycle frame_crc <= crc, frame_count++, and frame_valid=1 for one cycle. The MEASURE->LOCKED transition frame also publishes.
- clear: zeroes err_* and frame_count the next cycle. If it coincides with a publish, the clear wins: frame_count=0 and frame_crc updates.
- Sticky flags are set even while clear is low and persist across lock loss.
- Mid-frame reset: asynchronous return to SEARCH with all state zeroed. Nothing is published for the partial frame.

Test Plan:
- Three ideal 800x525 all-black frames, SYNC_NEG=1 -> locked=1 after frame 2's vs rise +1 cycle; frame_valid pulses; frame_crc=0x0000; frame_count counts 1,2; no errors.
- Same stream, single pixel 0x3F at active (0,0), i.e. x=144, y=35 -> frame_crc=0x801F, no err_blank.
- One line lengthened to 801 clocks while LOCKED -> err_h=1, locked=0 within 2 cycles; relock after the next clean frame; err_h stays set until clear.
- vsync width of 3 lines -> err_v=1, locked never asserted in that frame.
- RGB=0x01 at x=10 of a line (in sync) -> err_blank=1, locked stays 1; clear pulse -> err_blank=0 and frame_count=0 next cycle.
- rst_n low for 1 cycle mid-frame in LOCKED -> all outputs 0 immediately; next published frame occurs only after SEARCH->MEASURE->LOCKED.
